can_stuff_tx: RTL and testbench
===============================

CAN_STUFF_TX -- requirements
Module: can_stuff_tx

Interface
REQ-001 SHALL have parameter STUFF_LIMIT, default 5: number of consecutive identical bits that triggers a stuff bit.
REQ-002 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock, all state.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  one-cycle request to transmit latched fields; honoured only in IDLE.
REQ-005 bitPulse  in  1  one-cycle strobe per CAN bit time; each pulse advances transmission by one bit.
REQ-006 msgId  in  11  standard identifier, MSB sent first.
REQ-007 rtr  in  1  remote request bit; 1 = no data field.
REQ-008 msgSize  in  4  DLC, sent MSB first.
REQ-009 msgData  in  64  payload; byte0 = msgData[63:56], sent first, MSB first.
REQ-010 dOut  out  1  registered bus bit; 1 = recessive.
REQ-011 busy  out  1  high from the cycle after accepted start until return to IDLE.
REQ-012 stuffInserted  out  1  one-cycle pulse when the bit just driven is a stuff bit.
REQ-013 txDone  out  1  one-cycle pulse on frame completion.

Function
REQ-014 SHALL latch msgId, rtr, msgSize and msgData on an accepted start; input changes afterward SHALL NOT affect the frame.
REQ-015 The FSM SHALL have states IDLE, ARMED, STUFFED, TAIL and DONE.
REQ-016 IDLE -> ARMED on start; ARMED -> STUFFED on the next bitPulse; STUFFED -> TAIL after the last CRC bit and any pending stuff bit; TAIL -> DONE after 10 bits; DONE -> IDLE after one cycle.
REQ-017 dOut SHALL update on the clock edge after a bitPulse and SHALL hold until the next bitPulse.
REQ-018 The stuffed region SHALL be: SOF(0), ID[10:0], RTR, IDE(0), r0(0), DLC[3:0], data, CRC[14:0].
REQ-019 The data bit count SHALL be 0 when rtr=1, otherwise min(msgSize,8)*8; DLC values 9-15 SHALL be sent unchanged and carry 64 data bits.
REQ-020 CRC SHALL be CRC-15 (polynomial 0x4599, init 0) over the unstuffed bits SOF through the last data bit, and SHALL be sent MSB first.
REQ-021 Stuffing: after STUFF_LIMIT consecutive identical driven bits in STUFFED, the next bitPulse SHALL drive the complement and pulse stuffInserted, and SHALL NOT advance the field pointer or the CRC.
REQ-022 A stuff bit SHALL count as the first bit of the next run (00000,1,1111,0 pattern).
REQ-023 A stuff bit due after CRC[0] SHALL be sent before TAIL.
REQ-024 TAIL SHALL drive 10 recessive unstuffed bits: CRC delimiter, ACK slot, ACK delimiter, 7 EOF.
REQ-025 On the bitPulse following the 10th TAIL bit, the FSM SHALL enter DONE; txDone SHALL be high in DONE; busy SHALL drop when IDLE is re-entered.
REQ-026 start while not IDLE SHALL be ignored.
REQ-027 bitPulse in IDLE SHALL be ignored.
REQ-028 start and bitPulse in the same IDLE cycle SHALL accept start; SOF SHALL go out on the following bitPulse.
REQ-029 Total bitPulses from ARMED to DONE SHALL equal 34 + data bits + stuff bits + 10 + 1.

Reset
REQ-030 Reset SHALL force IDLE, dOut=1, busy=0, txDone=0, stuffInserted=0, run counter cleared, CRC=0, immediately and asynchronously, including mid-frame.
REQ-031 After reset release, the first start SHALL produce a complete, correct frame.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, CRC15_POLY=15'h4599, TAIL_LEN=10, EOF_LEN=7 and the field-length constants.
REQ-033 The CRC SHALL be a separate sub-module can_crc15 with inputs clear, shift and dIn and a 15-bit output.

Verification
REQ-034 ID=0x000, rtr=0, DLC=0: dOut bits 1-5 = 0, bit 6 = 1 (stuff), stuffInserted once per 5 zeros; CRC=0x0000; the frame completes with txDone.
REQ-035 ID=0x7FF, rtr=1, DLC=0: SOF 0, then five 1s, then stuff 0, then remaining ID 1s; no data bits.
REQ-036 ID=0x555, DLC=2, data 0xAA55...: no stuff bits in the ID or data; the bitPulse count to txDone matches REQ-029.
REQ-037 DLC=9, rtr=0: 64 data bits are sent; DLC field on the wire is 1001.
REQ-038 Assert reset mid-data: dOut=1 and busy=0 in the same cycle; the next start transmits correctly.
REQ-039 A second start while busy is ignored; start coincident with bitPulse in IDLE: SOF appears on the next bitPulse.

Source files
------------

// File: rtl/can_stuff_tx_pkg.sv
// ---------------------------------------------------------------------------
// can_stuff_tx_pkg
// Shared definitions for the CAN base-frame transmitter with bit stuffing:
//   - txState_t    : transmitter FSM states
//   - CRC15_POLY   : CAN CRC-15 generator polynomial
//   - field lengths: SOF/ID/control/CRC/tail/EOF bit counts
//   - dataBitCount : number of payload bits carried for a given RTR/DLC
// ---------------------------------------------------------------------------
package can_stuff_tx_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    STUFFED = 3'd2,
    TAIL    = 3'd3,
    DONE    = 3'd4
  } txState_t;

  localparam logic [14:0] CRC15_POLY = 15'h4599;

  // Field lengths of the stuffed region (SOF .. DLC form the header).
  localparam int SOF_LEN  = 1;
  localparam int ID_LEN   = 11;
  localparam int RTR_LEN  = 1;
  localparam int IDE_LEN  = 1;
  localparam int R0_LEN   = 1;
  localparam int DLC_LEN  = 4;
  localparam int HDR_LEN  = SOF_LEN + ID_LEN + RTR_LEN + IDE_LEN + R0_LEN + DLC_LEN;
  localparam int DATA_MAX_BITS = 64;
  localparam int CRC_LEN  = 15;

  // Unstuffed trailer: CRC delimiter, ACK slot, ACK delimiter, EOF.
  localparam int EOF_LEN  = 7;
  localparam int TAIL_LEN = 10;

  // Header plus the largest payload, held in one shift register.
  localparam int FRAME_SH_LEN = HDR_LEN + DATA_MAX_BITS;

  // Payload bit count: none for remote frames, DLC 9..15 still carry 8 bytes.
  function automatic logic [6:0] dataBitCount(input logic rtr, input logic [3:0] dlc);
    logic [6:0] n;
    if (rtr)
      n = 7'd0;
    else if (dlc >= 4'd8)
      n = 7'd64;
    else
      n = {1'b0, dlc[2:0], 3'b000};
    return n;
  endfunction

endpackage

// File: rtl/can_stuff_tx_if.sv
// ---------------------------------------------------------------------------
// can_stuff_tx_if
// Request/bus signals of the CAN transmitter.
//   master : frame requester (drives start, bitPulse and the message fields)
//   slave  : transmitter (drives dOut, busy, stuffInserted, txDone)
// Signals:
//   start         one-cycle transmit request
//   bitPulse      one-cycle strobe per CAN bit time
//   msgId[10:0]   standard identifier
//   rtr           remote request (no data field)
//   msgSize[3:0]  DLC
//   msgData[63:0] payload, byte0 in [63:56]
//   dOut          bus bit, 1 = recessive
//   busy          frame in progress
//   stuffInserted the bit currently driven is a stuff bit (one cycle)
//   txDone        frame complete (one cycle)
// ---------------------------------------------------------------------------
interface can_stuff_tx_if;
  logic        start;
  logic        bitPulse;
  logic [10:0] msgId;
  logic        rtr;
  logic [3:0]  msgSize;
  logic [63:0] msgData;
  logic        dOut;
  logic        busy;
  logic        stuffInserted;
  logic        txDone;

  modport master (
    output start, bitPulse, msgId, rtr, msgSize, msgData,
    input  dOut, busy, stuffInserted, txDone
  );

  modport slave (
    input  start, bitPulse, msgId, rtr, msgSize, msgData,
    output dOut, busy, stuffInserted, txDone
  );
endinterface

// File: rtl/can_crc15.sv
// ---------------------------------------------------------------------------
// can_crc15
// Serial CAN CRC-15 (polynomial 0x4599, initial value 0).
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset, clears the register
//   clear  synchronous clear to 0 (start of a new frame)
//   shift  fold dIn into the CRC this cycle
//   dIn    serial data bit
//   crc    current CRC register
// ---------------------------------------------------------------------------
module can_crc15
  import can_stuff_tx_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift,
  input  logic        dIn,
  output logic [14:0] crc
);

  logic [14:0] crcNext;
  logic        feedback;

  always_comb begin
    crcNext  = crc;
    feedback = dIn ^ crc[14];
    if (clear) begin
      crcNext = '0;
    end else if (shift) begin
      crcNext = {crc[13:0], 1'b0};
      if (feedback)
        crcNext = crcNext ^ CRC15_POLY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      crc <= '0;
    else
      crc <= crcNext;
  end

endmodule

// File: rtl/can_stuff_tx.sv
// ---------------------------------------------------------------------------
// can_stuff_tx
// CAN 2.0A base-frame transmitter with bit stuffing. One bit goes out per
// bitPulse; dOut is registered and holds between pulses.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset (any time, including mid-frame)
//   bus    can_stuff_tx_if.slave: start/bitPulse/message fields in,
//          dOut/busy/stuffInserted/txDone out
// Parameter:
//   STUFF_LIMIT  run length of identical bits that forces a stuff bit
// Frame order: SOF, ID, RTR, IDE, r0, DLC, data, CRC (stuffed), then ten
// recessive unstuffed tail bits (CRC delim, ACK, ACK delim, EOF).
// ---------------------------------------------------------------------------
module can_stuff_tx
  import can_stuff_tx_pkg::*;
#(
  parameter int STUFF_LIMIT = 5
) (
  input  logic           clk,
  input  logic           reset,
  can_stuff_tx_if.slave  bus
);

  localparam int RUN_W = $clog2(STUFF_LIMIT + 1);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(STUFF_LIMIT);
  localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);
  localparam logic [3:0]       TAIL_LAST = 4'(TAIL_LEN);
  localparam logic [4:0]       CRC_COUNT = 5'(CRC_LEN);

  txState_t                  state, stateNext;
  logic [FRAME_SH_LEN-1:0]   frameSh, frameShNext;       // header + payload, MSB goes next
  logic [6:0]                hdrDataLen, hdrDataLenNext; // header + payload bits to send
  logic [6:0]                ptr, ptrNext;               // header/payload bits already sent
  logic [4:0]                crcCnt, crcCntNext;         // CRC bits already sent
  logic [RUN_W-1:0]          runCnt, runCntNext;         // identical driven bits in a row
  logic                      lastBit, lastBitNext;       // last bit driven in the stuffed region
  logic [3:0]                tailCnt, tailCntNext;       // tail bits driven
  logic                      dOutReg, dOutNext;
  logic                      stuffReg, stuffNext;

  logic        crcClear;
  logic        crcShift;
  logic [14:0] crcValue;
  logic        hdrDataLeft;
  logic        crcLeft;
  logic [3:0]  crcIdx;
  logic        fieldBit;
  logic        stuffDue;

  can_crc15 uCrc (
    .clk   (clk),
    .reset (reset),
    .clear (crcClear),
    .shift (crcShift),
    .dIn   (fieldBit),
    .crc   (crcValue)
  );

  // Next unstuffed bit: header/payload first, then the CRC MSB first.
  // The CRC register is frozen once the last payload bit has been folded in.
  always_comb begin
    hdrDataLeft = (ptr < hdrDataLen);
    crcLeft     = (crcCnt < CRC_COUNT);
    crcIdx      = crcLeft ? (4'd14 - crcCnt[3:0]) : 4'd0;
    fieldBit    = hdrDataLeft ? frameSh[FRAME_SH_LEN-1] : crcValue[crcIdx];
    stuffDue    = (runCnt == RUN_LIMIT);
  end

  always_comb begin
    stateNext      = state;
    frameShNext    = frameSh;
    hdrDataLenNext = hdrDataLen;
    ptrNext        = ptr;
    crcCntNext     = crcCnt;
    runCntNext     = runCnt;
    lastBitNext    = lastBit;
    tailCntNext    = tailCnt;
    dOutNext       = dOutReg;
    stuffNext      = 1'b0;
    crcClear       = 1'b0;
    crcShift       = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          stateNext      = ARMED;
          frameShNext    = {1'b0, bus.msgId, bus.rtr, 1'b0, 1'b0, bus.msgSize, bus.msgData};
          hdrDataLenNext = 7'(HDR_LEN) + dataBitCount(bus.rtr, bus.msgSize);
          ptrNext        = '0;
          crcCntNext     = '0;
          runCntNext     = '0;
          lastBitNext    = 1'b1;
          tailCntNext    = '0;
          dOutNext       = 1'b1;
          crcClear       = 1'b1;
        end
      end

      // SOF opens the stuffed region and the first run.
      ARMED: begin
        if (bus.bitPulse) begin
          stateNext   = STUFFED;
          dOutNext    = fieldBit;
          frameShNext = {frameSh[FRAME_SH_LEN-2:0], 1'b0};
          ptrNext     = ptr + 7'd1;
          crcShift    = 1'b1;
          runCntNext  = RUN_ONE;
          lastBitNext = fieldBit;
        end
      end

      STUFFED: begin
        if (bus.bitPulse) begin
          if (stuffDue) begin
            // Stuff bit: complement, starts the next run, no field/CRC advance.
            // Checked before the end test so a stuff bit owed after CRC[0]
            // still goes out before the tail.
            dOutNext    = ~lastBit;
            lastBitNext = ~lastBit;
            runCntNext  = RUN_ONE;
            stuffNext   = 1'b1;
          end else if (hdrDataLeft || crcLeft) begin
            dOutNext = fieldBit;
            if (hdrDataLeft) begin
              frameShNext = {frameSh[FRAME_SH_LEN-2:0], 1'b0};
              ptrNext     = ptr + 7'd1;
              crcShift    = 1'b1;
            end else begin
              crcCntNext  = crcCnt + 5'd1;
            end
            if (fieldBit == lastBit)
              runCntNext = runCnt + RUN_ONE;
            else
              runCntNext = RUN_ONE;
            lastBitNext = fieldBit;
          end else begin
            // First tail bit (CRC delimiter).
            stateNext   = TAIL;
            dOutNext    = 1'b1;
            tailCntNext = 4'd1;
          end
        end
      end

      TAIL: begin
        if (bus.bitPulse) begin
          if (tailCnt == TAIL_LAST) begin
            stateNext = DONE;
          end else begin
            tailCntNext = tailCnt + 4'd1;
            dOutNext    = 1'b1;
          end
        end
      end

      DONE: begin
        stateNext = IDLE;
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      frameSh    <= '0;
      hdrDataLen <= '0;
      ptr        <= '0;
      crcCnt     <= '0;
      runCnt     <= '0;
      lastBit    <= 1'b1;
      tailCnt    <= '0;
      dOutReg    <= 1'b1;
      stuffReg   <= 1'b0;
    end else begin
      state      <= stateNext;
      frameSh    <= frameShNext;
      hdrDataLen <= hdrDataLenNext;
      ptr        <= ptrNext;
      crcCnt     <= crcCntNext;
      runCnt     <= runCntNext;
      lastBit    <= lastBitNext;
      tailCnt    <= tailCntNext;
      dOutReg    <= dOutNext;
      stuffReg   <= stuffNext;
    end
  end

  // busy/txDone decode the state register, so reset clears them at once.
  assign bus.dOut          = dOutReg;
  assign bus.stuffInserted = stuffReg;
  assign bus.busy          = (state != IDLE);
  assign bus.txDone        = (state == DONE);

endmodule

// File: tb/tb_can_stuff_tx.sv
`timescale 1ns/1ps
module tb_can_stuff_tx;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  can_stuff_tx_if bus ();

  can_stuff_tx #(.STUFF_LIMIT(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int compared   = 0;
  int mismatched = 0;

  // Expected wire (one entry per bitPulse, including the pulse into DONE).
  logic expBit   [0:255];
  logic expStuff [0:255];
  int   expLen;
  // Observed wire, sampled after each bitPulse.
  logic gotBit   [0:255];
  logic gotStuff [0:255];
  int   gotLen;
  logic gotDone;

  // Reference frame: list the unstuffed bits, append the CRC, then stuff.
  task automatic buildExpected(input logic [10:0] id, input logic r,
                               input logic [3:0] dlc, input logic [63:0] data);
    logic        raw[$];
    logic [14:0] crc;
    logic        fb;
    logic        last;
    int          run;
    int          nData;
    raw = {};
    raw.push_back(1'b0);
    for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
    raw.push_back(r);
    raw.push_back(1'b0);
    raw.push_back(1'b0);
    for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
    nData = r ? 0 : ((dlc > 4'd8) ? 64 : int'(dlc) * 8);
    for (int i = 0; i < nData; i++) raw.push_back(data[63-i]);
    crc = '0;
    foreach (raw[i]) begin
      fb  = raw[i] ^ crc[14];
      crc = {crc[13:0], 1'b0};
      if (fb) crc = crc ^ 15'h4599;
    end
    for (int i = 14; i >= 0; i--) raw.push_back(crc[i]);
    expLen = 0;
    run    = 0;
    last   = 1'b1;
    foreach (raw[i]) begin
      expBit[expLen] = raw[i]; expStuff[expLen] = 1'b0; expLen++;
      if (raw[i] == last) run++;
      else begin run = 1; last = raw[i]; end
      if (run == 5) begin
        expBit[expLen] = ~last; expStuff[expLen] = 1'b1; expLen++;
        last = ~last; run = 1;
      end
    end
    for (int i = 0; i < 11; i++) begin
      expBit[expLen] = 1'b1; expStuff[expLen] = 1'b0; expLen++;
    end
  endtask

  task automatic pulse();
    @(negedge clk);
    bus.bitPulse = 1'b1;
    @(negedge clk);
    bus.bitPulse = 1'b0;
  endtask

  task automatic startFrame(input string name, input logic [10:0] id, input logic r,
                            input logic [3:0] dlc, input logic [63:0] data,
                            input logic coincident);
    @(negedge clk);
    bus.msgId    = id;
    bus.rtr      = r;
    bus.msgSize  = dlc;
    bus.msgData  = data;
    bus.start    = 1'b1;
    bus.bitPulse = coincident;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.bitPulse = 1'b0;
    // Scramble the inputs: the frame must come from the latched copy.
    bus.msgId    = ~id;
    bus.rtr      = ~r;
    bus.msgSize  = ~dlc;
    bus.msgData  = ~data;
    compared++;
    if (bus.busy !== 1'b1 || bus.dOut !== 1'b1) begin
      mismatched++;
      $display("FAIL %s start: busy=%b dOut=%b, required busy=1 dOut=1", name, bus.busy, bus.dOut);
    end
  endtask

  function automatic int gotStuffCount();
    int n = 0;
    for (int i = 0; i < gotLen; i++) if (gotStuff[i] === 1'b1) n++;
    return n;
  endfunction

  // Pulse until txDone, then compare the whole wire to the reference.
  // injectAt >= 0 raises a second start (other fields) after that many bits.
  task automatic collectFrame(input string name, input int injectAt);
    logic [255:0] gv, ev, gs, es;
    gotLen  = 0;
    gotDone = 1'b0;
    while (!gotDone && gotLen < 250) begin
      if (gotLen == injectAt) begin
        @(negedge clk);
        bus.msgId = 11'h000; bus.rtr = 1'b0; bus.msgSize = 4'd8; bus.msgData = '0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
      end
      pulse();
      gotBit[gotLen]   = bus.dOut;
      gotStuff[gotLen] = bus.stuffInserted;
      gotLen++;
      if (bus.txDone === 1'b1) gotDone = 1'b1;
      if (gotLen == 6) begin
        // One idle cycle later: bit held, stuff flag already gone.
        @(negedge clk);
        compared++;
        if (bus.dOut !== gotBit[5] || bus.stuffInserted !== 1'b0) begin
          mismatched++;
          $display("FAIL %s hold: dOut=%b stuffInserted=%b, required dOut=%b stuffInserted=0",
                   name, bus.dOut, bus.stuffInserted, gotBit[5]);
        end
      end
    end
    compared++;
    if (!gotDone) begin
      mismatched++;
      $display("FAIL %s txDone: not seen after %0d bitPulses, required after %0d", name, gotLen, expLen);
    end
    compared++;
    if (gotLen != expLen) begin
      mismatched++;
      $display("FAIL %s pulseCount: got %0d, required %0d", name, gotLen, expLen);
    end
    gv = '0; ev = '0; gs = '0; es = '0;
    for (int i = 0; i < 256; i++) begin
      if (i < gotLen) begin gv[i] = gotBit[i]; gs[i] = gotStuff[i]; end
      if (i < expLen) begin ev[i] = expBit[i]; es[i] = expStuff[i]; end
    end
    compared++;
    if (gv !== ev) begin
      mismatched++;
      $display("FAIL %s wire: got %h required %h", name, gv, ev);
    end
    compared++;
    if (gs !== es) begin
      mismatched++;
      $display("FAIL %s stuffFlags: got %h required %h", name, gs, es);
    end
    @(negedge clk);
    compared++;
    if (bus.busy !== 1'b0 || bus.txDone !== 1'b0) begin
      mismatched++;
      $display("FAIL %s idleAfter: busy=%b txDone=%b, required 0 0", name, bus.busy, bus.txDone);
    end
    $display("frame %s: %0d bitPulses, %0d stuff bits", name, gotLen, gotStuffCount());
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.bitPulse = 1'b0;
    bus.msgId = '0; bus.rtr = 1'b0; bus.msgSize = '0; bus.msgData = '0;
    repeat (2) @(negedge clk);
    compared++;
    if (bus.dOut !== 1'b1 || bus.busy !== 1'b0 || bus.txDone !== 1'b0 || bus.stuffInserted !== 1'b0) begin
      mismatched++;
      $display("FAIL reset: dOut=%b busy=%b txDone=%b stuff=%b, required 1 0 0 0",
               bus.dOut, bus.busy, bus.txDone, bus.stuffInserted);
    end
    reset = 1'b0;
    // bitPulse with no frame requested does nothing.
    pulse();
    compared++;
    if (bus.dOut !== 1'b1 || bus.busy !== 1'b0) begin
      mismatched++;
      $display("FAIL idlePulse: dOut=%b busy=%b, required 1 0", bus.dOut, bus.busy);
    end
  endtask

  task automatic test_zero_frame();
    logic [5:0] w6, s6;
    buildExpected(11'h000, 1'b0, 4'd0, 64'h0);
    startFrame("zero", 11'h000, 1'b0, 4'd0, 64'h0, 1'b0);
    collectFrame("zero", -1);
    for (int i = 0; i < 6; i++) begin w6[5-i] = gotBit[i]; s6[5-i] = gotStuff[i]; end
    compared++;
    if (w6 !== 6'b000001 || s6 !== 6'b000001) begin
      mismatched++;
      $display("FAIL zero first6: wire=%b stuff=%b, required 000001 000001", w6, s6);
    end
    compared++;
    if (gotStuffCount() != 6 || gotLen != 51) begin
      mismatched++;
      $display("FAIL zero counts: stuff=%0d pulses=%0d, required 6 51", gotStuffCount(), gotLen);
    end
  endtask

  task automatic test_ones_rtr();
    logic [12:0] w13, s13;
    buildExpected(11'h7FF, 1'b1, 4'd0, 64'h0);
    startFrame("onesRtr", 11'h7FF, 1'b1, 4'd0, 64'h0, 1'b0);
    collectFrame("onesRtr", -1);
    for (int i = 0; i < 13; i++) begin w13[12-i] = gotBit[i]; s13[12-i] = gotStuff[i]; end
    compared++;
    if (w13 !== 13'b0111110111110 || s13 !== 13'b0000001000001) begin
      mismatched++;
      $display("FAIL onesRtr first13: wire=%b stuff=%b, required 0111110111110 0000001000001", w13, s13);
    end
    compared++;
    if (gotLen - gotStuffCount() != 45) begin
      mismatched++;
      $display("FAIL onesRtr unstuffed: got %0d, required 45", gotLen - gotStuffCount());
    end
  endtask

  task automatic test_alt_pattern();
    logic [15:0] d16;
    logic [35:0] s36;
    buildExpected(11'h555, 1'b0, 4'd2, 64'hAA55_0000_0000_0000);
    startFrame("alt", 11'h555, 1'b0, 4'd2, 64'hAA55_0000_0000_0000, 1'b0);
    collectFrame("alt", -1);
    for (int i = 0; i < 16; i++) d16[15-i] = gotBit[20+i];
    for (int i = 0; i < 36; i++) s36[35-i] = gotStuff[i];
    compared++;
    if (d16 !== 16'hAA55) begin
      mismatched++;
      $display("FAIL alt data: got %h, required aa55", d16);
    end
    compared++;
    if (s36 !== 36'h0_0004_0000 || gotBit[17] !== 1'b1) begin
      mismatched++;
      $display("FAIL alt stuffPos: flags=%b bit17=%b, required one stuff at bit 17 (1)", s36, gotBit[17]);
    end
    compared++;
    if (gotLen - gotStuffCount() != 61) begin
      mismatched++;
      $display("FAIL alt unstuffed: got %0d, required 61", gotLen - gotStuffCount());
    end
  endtask

  task automatic test_dlc9();
    logic [3:0]  dlcWire;
    logic [18:0] s19;
    buildExpected(11'h555, 1'b0, 4'd9, 64'h0123_4567_89AB_CDEF);
    startFrame("dlc9", 11'h555, 1'b0, 4'd9, 64'h0123_4567_89AB_CDEF, 1'b0);
    collectFrame("dlc9", -1);
    for (int i = 0; i < 4; i++) dlcWire[3-i] = gotBit[15+i];
    for (int i = 0; i < 19; i++) s19[18-i] = gotStuff[i];
    compared++;
    if (dlcWire !== 4'b1001 || s19 !== 19'h0) begin
      mismatched++;
      $display("FAIL dlc9 dlcField: got %b flags=%b, required 1001 no stuff", dlcWire, s19);
    end
    compared++;
    if (gotLen - gotStuffCount() != 109) begin
      mismatched++;
      $display("FAIL dlc9 unstuffed: got %0d, required 109", gotLen - gotStuffCount());
    end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    startFrame("midReset", 11'h123, 1'b0, 4'd8, 64'hFEDC_BA98_7654_3210, 1'b0);
    for (int i = 0; i < 25; i++) pulse();
    n = 0;
    while (bus.dOut !== 1'b0 && n < 30) begin pulse(); n++; end
    compared++;
    if (bus.dOut !== 1'b0 || bus.busy !== 1'b1) begin
      mismatched++;
      $display("FAIL midReset setup: dOut=%b busy=%b, required 0 1", bus.dOut, bus.busy);
    end
    #2 reset = 1'b1;
    #1;
    compared++;
    if (bus.dOut !== 1'b1 || bus.busy !== 1'b0 || bus.txDone !== 1'b0 || bus.stuffInserted !== 1'b0) begin
      mismatched++;
      $display("FAIL midReset async: dOut=%b busy=%b txDone=%b stuff=%b, required 1 0 0 0",
               bus.dOut, bus.busy, bus.txDone, bus.stuffInserted);
    end
    @(negedge clk);
    reset = 1'b0;
    buildExpected(11'h2A5, 1'b0, 4'd3, 64'h00FF_3C00_0000_0000);
    startFrame("afterReset", 11'h2A5, 1'b0, 4'd3, 64'h00FF_3C00_0000_0000, 1'b0);
    collectFrame("afterReset", -1);
  endtask

  task automatic test_back_to_back();
    buildExpected(11'h1A3, 1'b0, 4'd1, 64'h5A00_0000_0000_0000);
    startFrame("coincident", 11'h1A3, 1'b0, 4'd1, 64'h5A00_0000_0000_0000, 1'b1);
    collectFrame("coincident", 3);
    compared++;
    if (gotBit[0] !== 1'b0) begin
      mismatched++;
      $display("FAIL coincident sof: got %b, required 0", gotBit[0]);
    end
    buildExpected(11'h7F0, 1'b0, 4'd8, 64'hFFFF_FFFF_0000_0000);
    startFrame("second", 11'h7F0, 1'b0, 4'd8, 64'hFFFF_FFFF_0000_0000, 1'b0);
    collectFrame("second", -1);
  endtask

  initial begin
    test_reset();
    test_zero_frame();
    test_ones_rtr();
    test_alt_pattern();
    test_dlc9();
    test_reset_mid_frame();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion before it");
    $fatal(1, "watchdog");
  end

endmodule
